dmem_bridge: RTL

Memory-stage data-memory bridge. It sits directly downstream of the pipelined MIPS core's memory stage and converts each load/store request (address, write data, size, signedness) into a single byte-enabled request/acknowledge transaction on a variable-latency SRAM-like bus. While a transaction is outstanding it holds the pipeline with `stall_o`. It returns load data already lane-selected and sign- or zero-extended, and it flags misaligned accesses instead of issuing them.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/load_ext.sv | 25 ++
 rtl/dmem_bridge.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory bridge: size codes, FSM state type,
// and the byte-enable / alignment / store-lane helpers.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Size code 2'b11 falls into the default arm everywhere, i.e. behaves as a word.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lo;
      SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      default: misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: lane_rep = {4{wdata[7:0]}};
      SZ_HALF: lane_rep = {2{wdata[15:0]}};
      default: lane_rep = wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load-data lane select plus sign/zero extension of the raw bus read word.
module load_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lo_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{lo_i, 3'b000} +: 8];
    half_sel = lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{sext_i & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// M-stage to request/ack SRAM bus bridge: one transaction per load/store,
// pipeline stall while outstanding, misaligned accesses flagged, not issued.
module dmem_bridge
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en_i,
  input  logic              mem_wen_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_sext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              bus_req_o,
  output logic              bus_wr_o,
  output logic [3:0]        bus_be_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [1:0]        dbg_state_o
);

  // Handshake: bus_req_o rises on the edge leaving IDLE and stays high with
  // addr/be/wr/wdata frozen until the first cycle bus_ack_i is high; that same
  // cycle carries the read word, and req drops on the following edge.

  state_t            state_q;
  logic              req_q, wr_q, sext_q;
  logic [3:0]        be_q;
  logic [1:0]        size_q, lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  logic              mis_d, start_d;
  logic [DATA_W-1:0] ext_d;

  assign mis_d   = misaligned(mem_size_i, addr_i[1:0]);
  assign start_d = (state_q == ST_IDLE) && mem_en_i && !mis_d;

  load_ext u_load_ext (
    .rdata_i (bus_rdata_i),
    .lo_i    (lo_q),
    .size_i  (size_q),
    .sext_i  (sext_q),
    .data_o  (ext_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      be_q    <= 4'b0000;
      size_q  <= SZ_BYTE;
      lo_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_d) begin
            wr_q    <= mem_wen_i;
            sext_q  <= mem_sext_i;
            be_q    <= byte_en(mem_size_i, addr_i[1:0]);
            size_q  <= mem_size_i;
            lo_q    <= addr_i[1:0];
            addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
            wdata_q <= lane_rep(mem_size_i, wdata_i);
            req_q   <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus_ack_i) begin
            req_q   <= 1'b0;
            if (!wr_q) rdata_q <= ext_d;
            state_q <= ST_DONE;
          end
        end
        // DONE always returns to IDLE so the held M-stage instruction is not re-issued.
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall_o     = rst && (start_d || (state_q == ST_BUSY));
  assign adel_o      = rst && (state_q == ST_IDLE) && mem_en_i && mis_d && !mem_wen_i;
  assign ades_o      = rst && (state_q == ST_IDLE) && mem_en_i && mis_d && mem_wen_i;
  assign bus_req_o   = req_q;
  assign bus_wr_o    = wr_q;
  assign bus_be_o    = be_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign dbg_state_o = state_q;

endmodule
